// File: rtl/enc4to2_seq.sv
// Registered priority encoder: captures a multi-hot request vector and emits one
// binary index per handshake until the batch drains. Define ENC_ROUND_ROBIN_EN for rotating priority.
module enc4to2_seq #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [W-1:0] code,
    output logic         code_last,
    output logic [N-1:0] pend
);

    typedef enum logic [0:0] {IDLE = 1'b0, SERVE = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] code_q, code_d;
    logic         code_valid_q, code_valid_d;
    logic         code_last_q, code_last_d;
    logic         req_ready_q, req_ready_d;
    logic [N-1:0] remain_s;
    logic         accept_s;
    logic [W-1:0] cap_start_s;
    logic [W-1:0] next_start_s;

    function automatic logic is_single(input logic [N-1:0] v);
        return (v != {N{1'b0}}) && ((v & (v - N'(1))) == {N{1'b0}});
    endfunction

    // First set bit found scanning upward from start, wrapping at N (N is a power of 2).
    function automatic logic [W-1:0] pick(input logic [N-1:0] v, input logic [W-1:0] start);
        logic [W-1:0] idx;
        logic [W-1:0] c;
        logic         found;
        idx   = start;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            c     = start + W'(i);
            idx   = (!found && v[c]) ? c : idx;
            found = found | v[c];
        end
        return idx;
    endfunction

    assign remain_s = pend_q & ~(N'(1) << code_q);
    assign accept_s = code_valid_q & code_ready & en;

`ifdef ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    assign cap_start_s  = ptr_q;
    assign next_start_s = code_q + W'(1);

    // Rotating pointer advances past every served index and persists across batches.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s) begin
            ptr_d = next_start_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign cap_start_s  = {W{1'b0}};
    assign next_start_s = {W{1'b0}};
`endif

    // Next-state and output logic; en low freezes state and pend while dropping both valids.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        code_last_d  = code_last_q;
        req_ready_d  = 1'b0;
        if (!en) begin
            code_valid_d = 1'b0;
            req_ready_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_d = 1'b1;
                    if (req_valid && req_ready_q && (req != {N{1'b0}})) begin
                        pend_d       = req;
                        code_d       = pick(req, cap_start_s);
                        code_last_d  = is_single(req);
                        code_valid_d = 1'b1;
                        req_ready_d  = 1'b0;
                        state_d      = SERVE;
                    end else begin
                        req_ready_d = 1'b1;
                    end
                end
                SERVE: begin
                    code_valid_d = 1'b1;
                    if (accept_s) begin
                        pend_d = remain_s;
                        if (remain_s != {N{1'b0}}) begin
                            code_d      = pick(remain_s, next_start_s);
                            code_last_d = is_single(remain_s);
                        end else begin
                            code_valid_d = 1'b0;
                            code_last_d  = 1'b0;
                            req_ready_d  = 1'b1;
                            state_d      = IDLE;
                        end
                    end else begin
                        code_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    pend_d       = {N{1'b0}};
                    code_valid_d = 1'b0;
                    code_last_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= {N{1'b0}};
            code_q       <= {W{1'b0}};
            code_valid_q <= 1'b0;
            code_last_q  <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            code_last_q  <= code_last_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign code_valid = code_valid_q;
    assign code       = code_q;
    assign code_last  = code_last_q;
    assign pend       = pend_q;

endmodule
